// File: rtl/iq_pkg.sv
// Shared definitions for the instruction queue path.
// Holds base-word field positions, the extension address width,
// the parcel decoder FSM states and the decoded-instruction struct
// that instruction_queue also stores.
package iq_pkg;

  localparam int ADDR_W = 48;

  // Base-word field positions
  localparam int MAJOR_HI    = 31;
  localparam int MAJOR_LO    = 28;
  localparam int SRC1_HI     = 27;
  localparam int SRC1_LO     = 23;
  localparam int SRC2_HI     = 22;
  localparam int SRC2_LO     = 18;
  localparam int OSCALE_HI   = 17;
  localparam int OSCALE_LO   = 16;
  localparam int DEST_HI     = 15;
  localparam int DEST_LO     = 11;
  localparam int MINOR_HI    = 10;
  localparam int MINOR_LO    = 7;
  localparam int HASADDR_BIT = 6;
  localparam int OFFSUB_BIT  = 5;
  localparam int RSVD_HI     = 4;
  localparam int RSVD_LO     = 0;

  typedef enum logic [2:0] {
    BASE_HI = 3'd0,
    BASE_LO = 3'd1,
    ADDR0   = 3'd2,
    ADDR1   = 3'd3,
    ADDR2   = 3'd4,
    EMIT    = 3'd5
  } dec_state_t;

  typedef struct packed {
    logic [3:0]        major_op;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic [1:0]        off_scale;
    logic [4:0]        dest;
    logic [3:0]        minor_op;
    logic              has_addr;
    logic              off_sub;
    logic [ADDR_W-1:0] address;
  } decoded_t;

endpackage

// File: rtl/iq_field_extract.sv
// Combinational slicing of a 32-bit base word into instruction fields.
// Ports:
//   base     - assembled 32-bit base word
//   addr     - extension address to carry along (caller zeroes it when unused)
//   dec      - decoded instruction
//   rsvd_err - reserved bits [4:0] are nonzero
module iq_field_extract
  import iq_pkg::*;
(
  input  logic [31:0]       base,
  input  logic [ADDR_W-1:0] addr,
  output decoded_t          dec,
  output logic              rsvd_err
);

  assign dec.major_op  = base[MAJOR_HI:MAJOR_LO];
  assign dec.src1      = base[SRC1_HI:SRC1_LO];
  assign dec.src2      = base[SRC2_HI:SRC2_LO];
  assign dec.off_scale = base[OSCALE_HI:OSCALE_LO];
  assign dec.dest      = base[DEST_HI:DEST_LO];
  assign dec.minor_op  = base[MINOR_HI:MINOR_LO];
  assign dec.has_addr  = base[HASADDR_BIT];
  assign dec.off_sub   = base[OFFSUB_BIT];
  assign dec.address   = addr;
  assign rsvd_err      = |base[RSVD_HI:RSVD_LO];

endmodule

// File: rtl/instruction_parcel_decoder.sv
// Producer side of the instruction queue: gathers 16-bit fetch parcels
// into a 32-bit base word plus optional 48-bit address and presents the
// decoded fields to the queue, holding them while the queue is full.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   parcel_in/_valid_in   - fetch parcel stream; parcel_ready_out accepts
//   flush_in              - drop any partial or held instruction
//   queue_full_in         - queue backpressure
//   *_out fields          - registered decoded instruction
//   stall_out             - 1 when no instruction is presented
//   reserved_err_out      - presented instruction has nonzero bits [4:0]
//   instr_count_out       - instructions handed to the queue (wraps)
module instruction_parcel_decoder #(
  parameter int PARCEL_W = 16,  // only 16 supported
  parameter int ADDR_W   = 48,  // must be 3*PARCEL_W
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PARCEL_W-1:0] parcel_in,
  input  logic                parcel_valid_in,
  output logic                parcel_ready_out,
  input  logic                flush_in,
  input  logic                queue_full_in,
  output logic [3:0]          MajorOpcode_out,
  output logic [4:0]          Source1_out,
  output logic [4:0]          Source2_out,
  output logic [1:0]          OffsetScale_out,
  output logic [4:0]          Destination_out,
  output logic [3:0]          MinorOpcode_out,
  output logic                HasAddress_out,
  output logic                OffsetSub_out,
  output logic [ADDR_W-1:0]   Address_out,
  output logic                stall_out,
  output logic                reserved_err_out,
  output logic [CNT_W-1:0]    instr_count_out
);
  import iq_pkg::*;

  dec_state_t       state;
  logic             stall_q;
  logic [31:0]      base_q;
  logic [31:0]      addr_q;   // Address[47:16]; [15:0] arrives with the last parcel
  decoded_t         instr_q;
  logic             rsvd_q;
  logic [CNT_W-1:0] count_q;

  logic        xfer;
  logic [31:0] base_next;
  logic [ADDR_W-1:0] addr_next;
  decoded_t    dec;
  logic        rsvd;

  assign parcel_ready_out = (state != EMIT);
  assign xfer = parcel_valid_in && parcel_ready_out;

  // The decoder is loaded on entry to EMIT from one of two places:
  // BASE_LO (no address, low parcel live on the bus, address forced 0)
  // or ADDR2 (base already registered, last address parcel live).
  assign base_next = (state == BASE_LO) ? {base_q[31:16], parcel_in} : base_q;
  assign addr_next = (state == BASE_LO) ? '0 : {addr_q, parcel_in};

  iq_field_extract u_extract (
    .base     (base_next),
    .addr     (addr_next),
    .dec      (dec),
    .rsvd_err (rsvd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BASE_HI;
      stall_q <= 1'b1;
      base_q  <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      rsvd_q  <= 1'b0;
      count_q <= '0;
    end else if (flush_in) begin
      // Any parcel accepted this cycle is consumed and dropped; fields keep values.
      state   <= BASE_HI;
      stall_q <= 1'b1;
    end else begin
      case (state)
        BASE_HI: if (xfer) begin
          base_q[31:16] <= parcel_in;
          state         <= BASE_LO;
        end
        BASE_LO: if (xfer) begin
          base_q[15:0] <= parcel_in;
          if (parcel_in[HASADDR_BIT]) begin
            state <= ADDR0;
          end else begin
            state   <= EMIT;
            stall_q <= 1'b0;
            instr_q <= dec;
            rsvd_q  <= rsvd;
          end
        end
        ADDR0: if (xfer) begin
          addr_q[31:16] <= parcel_in;
          state         <= ADDR1;
        end
        ADDR1: if (xfer) begin
          addr_q[15:0] <= parcel_in;
          state        <= ADDR2;
        end
        ADDR2: if (xfer) begin
          state   <= EMIT;
          stall_q <= 1'b0;
          instr_q <= dec;
          rsvd_q  <= rsvd;
        end
        EMIT: if (!queue_full_in) begin
          state   <= BASE_HI;
          stall_q <= 1'b1;
          count_q <= count_q + CNT_W'(1);
        end
        default: begin
          state   <= BASE_HI;
          stall_q <= 1'b1;
        end
      endcase
    end
  end

  assign MajorOpcode_out  = instr_q.major_op;
  assign Source1_out      = instr_q.src1;
  assign Source2_out      = instr_q.src2;
  assign OffsetScale_out  = instr_q.off_scale;
  assign Destination_out  = instr_q.dest;
  assign MinorOpcode_out  = instr_q.minor_op;
  assign HasAddress_out   = instr_q.has_addr;
  assign OffsetSub_out    = instr_q.off_sub;
  assign Address_out      = instr_q.address;
  assign stall_out        = stall_q;
  assign reserved_err_out = rsvd_q;
  assign instr_count_out  = count_q;

endmodule

// File: tb/tb_instruction_parcel_decoder.sv
module tb_instruction_parcel_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] parcel_in;
  logic        parcel_valid_in;
  logic        parcel_ready_out;
  logic        flush_in;
  logic        queue_full_in;
  logic [3:0]  MajorOpcode_out;
  logic [4:0]  Source1_out;
  logic [4:0]  Source2_out;
  logic [1:0]  OffsetScale_out;
  logic [4:0]  Destination_out;
  logic [3:0]  MinorOpcode_out;
  logic        HasAddress_out;
  logic        OffsetSub_out;
  logic [47:0] Address_out;
  logic        stall_out;
  logic        reserved_err_out;
  logic [15:0] instr_count_out;

  int chk  = 0;
  int pass = 0;

  instruction_parcel_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .parcel_in        (parcel_in),
    .parcel_valid_in  (parcel_valid_in),
    .parcel_ready_out (parcel_ready_out),
    .flush_in         (flush_in),
    .queue_full_in    (queue_full_in),
    .MajorOpcode_out  (MajorOpcode_out),
    .Source1_out      (Source1_out),
    .Source2_out      (Source2_out),
    .OffsetScale_out  (OffsetScale_out),
    .Destination_out  (Destination_out),
    .MinorOpcode_out  (MinorOpcode_out),
    .HasAddress_out   (HasAddress_out),
    .OffsetSub_out    (OffsetSub_out),
    .Address_out      (Address_out),
    .stall_out        (stall_out),
    .reserved_err_out (reserved_err_out),
    .instr_count_out  (instr_count_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    parcel_in       = p;
    parcel_valid_in = 1'b1;
    tick();
    parcel_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk++; if (stall_out !== 1'b1) $display("FAIL reset_stall got=%0h exp=1", stall_out); else pass++;
    chk++; if (parcel_ready_out !== 1'b1) $display("FAIL reset_ready got=%0h exp=1", parcel_ready_out); else pass++;
    chk++; if (instr_count_out !== 16'h0) $display("FAIL reset_count got=%0h exp=0", instr_count_out); else pass++;
    chk++; if (Address_out !== 48'h0) $display("FAIL reset_addr got=%0h exp=0", Address_out); else pass++;
    chk++; if (MajorOpcode_out !== 4'h0) $display("FAIL reset_major got=%0h exp=0", MajorOpcode_out); else pass++;
    chk++; if (reserved_err_out !== 1'b0) $display("FAIL reset_rsvd got=%0h exp=0", reserved_err_out); else pass++;
  endtask

  task automatic test_plain;
    send(16'hFFFF);
    chk++; if (stall_out !== 1'b1) $display("FAIL plain_stall_mid got=%0h exp=1", stall_out); else pass++;
    send(16'hFF80);
    chk++; if (stall_out !== 1'b0) $display("FAIL plain_stall got=%0h exp=0", stall_out); else pass++;
    chk++; if (parcel_ready_out !== 1'b0) $display("FAIL plain_ready got=%0h exp=0", parcel_ready_out); else pass++;
    chk++; if ({MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out} !== {4'hF, 5'h1F, 5'h1F, 2'h3})
      $display("FAIL plain_hi_fields got=%0h exp=%0h", {MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out}, {4'hF, 5'h1F, 5'h1F, 2'h3});
    else pass++;
    chk++; if ({Destination_out, MinorOpcode_out, HasAddress_out, OffsetSub_out} !== {5'h1F, 4'hF, 1'b0, 1'b0})
      $display("FAIL plain_lo_fields got=%0h exp=%0h", {Destination_out, MinorOpcode_out, HasAddress_out, OffsetSub_out}, {5'h1F, 4'hF, 1'b0, 1'b0});
    else pass++;
    chk++; if (Address_out !== 48'h0) $display("FAIL plain_addr got=%0h exp=0", Address_out); else pass++;
    tick();
    chk++; if (instr_count_out !== 16'd1) $display("FAIL plain_count got=%0h exp=1", instr_count_out); else pass++;
    chk++; if (stall_out !== 1'b1) $display("FAIL plain_stall_after got=%0h exp=1", stall_out); else pass++;
  endtask

  task automatic test_address;
    send(16'hFFFF);
    send(16'hFFE0);
    send(16'h0000);
    send(16'h0000);
    chk++; if (stall_out !== 1'b1) $display("FAIL addr_stall_early got=%0h exp=1", stall_out); else pass++;
    send(16'h0062);
    chk++; if (stall_out !== 1'b0) $display("FAIL addr_stall got=%0h exp=0", stall_out); else pass++;
    chk++; if (Address_out !== 48'd98) $display("FAIL addr_value got=%0h exp=62", Address_out); else pass++;
    chk++; if ({HasAddress_out, OffsetSub_out, reserved_err_out} !== 3'b110)
      $display("FAIL addr_flags got=%0b exp=110", {HasAddress_out, OffsetSub_out, reserved_err_out}); else pass++;
    tick();
    chk++; if (instr_count_out !== 16'd2) $display("FAIL addr_count got=%0h exp=2", instr_count_out); else pass++;
  endtask

  task automatic test_backpressure;
    queue_full_in = 1'b1;
    send(16'h1234);
    send(16'h5A80);   // base 0x12345A80
    chk++; if ({MajorOpcode_out, Source1_out, Source2_out, Destination_out, MinorOpcode_out} !== {4'h1, 5'h04, 5'h0D, 5'h0B, 4'h5})
      $display("FAIL bp_fields got=%0h exp=%0h", {MajorOpcode_out, Source1_out, Source2_out, Destination_out, MinorOpcode_out}, {4'h1, 5'h04, 5'h0D, 5'h0B, 4'h5});
    else pass++;
    parcel_in       = 16'hFFFF;
    parcel_valid_in = 1'b1;   // must not be consumed while held
    for (int i = 0; i < 4; i++) begin
      tick();
      chk++; if ({stall_out, parcel_ready_out, MajorOpcode_out, MinorOpcode_out, instr_count_out} !== {1'b0, 1'b0, 4'h1, 4'h5, 16'd2})
        $display("FAIL bp_hold%0d got=%0h exp=%0h", i, {stall_out, parcel_ready_out, MajorOpcode_out, MinorOpcode_out, instr_count_out}, {1'b0, 1'b0, 4'h1, 4'h5, 16'd2});
      else pass++;
    end
    parcel_valid_in = 1'b0;
    queue_full_in   = 1'b0;
    tick();
    chk++; if ({stall_out, instr_count_out} !== {1'b1, 16'd3}) $display("FAIL bp_release got=%0h exp=%0h", {stall_out, instr_count_out}, {1'b1, 16'd3}); else pass++;
    tick();
    chk++; if (instr_count_out !== 16'd3) $display("FAIL bp_once got=%0h exp=3", instr_count_out); else pass++;
  endtask

  task automatic test_flush;
    send(16'hFFFF);
    send(16'hFFE0);
    send(16'h0001);   // ADDR0 transferred
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk++; if ({stall_out, parcel_ready_out, instr_count_out} !== {1'b1, 1'b1, 16'd3})
      $display("FAIL flush_state got=%0h exp=%0h", {stall_out, parcel_ready_out, instr_count_out}, {1'b1, 1'b1, 16'd3}); else pass++;
    send(16'h2000);
    send(16'h0000);
    chk++; if ({stall_out, MajorOpcode_out, HasAddress_out} !== {1'b0, 4'h2, 1'b0})
      $display("FAIL flush_fresh got=%0h exp=%0h", {stall_out, MajorOpcode_out, HasAddress_out}, {1'b0, 4'h2, 1'b0}); else pass++;
    chk++; if (Address_out !== 48'h0) $display("FAIL flush_fresh_addr got=%0h exp=0", Address_out); else pass++;
    tick();
    chk++; if (instr_count_out !== 16'd4) $display("FAIL flush_fresh_count got=%0h exp=4", instr_count_out); else pass++;
    // flush coinciding with an EMIT handoff drops the instruction
    send(16'h3000);
    send(16'h0000);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk++; if ({stall_out, instr_count_out, MajorOpcode_out} !== {1'b1, 16'd4, 4'h3})
      $display("FAIL flush_emit got=%0h exp=%0h", {stall_out, instr_count_out, MajorOpcode_out}, {1'b1, 16'd4, 4'h3}); else pass++;
    // flush overriding a BASE_HI transfer discards that parcel
    parcel_in       = 16'h7000;
    parcel_valid_in = 1'b1;
    flush_in        = 1'b1;
    tick();
    flush_in        = 1'b0;
    parcel_valid_in = 1'b0;
    send(16'h5000);
    send(16'h0000);
    chk++; if ({stall_out, MajorOpcode_out} !== {1'b0, 4'h5})
      $display("FAIL flush_xfer got=%0h exp=%0h", {stall_out, MajorOpcode_out}, {1'b0, 4'h5}); else pass++;
    tick();
  endtask

  task automatic test_reserved_reset;
    send(16'h4000);
    send(16'h0003);
    chk++; if ({stall_out, reserved_err_out, MajorOpcode_out} !== {1'b0, 1'b1, 4'h4})
      $display("FAIL rsvd_emit got=%0h exp=%0h", {stall_out, reserved_err_out, MajorOpcode_out}, {1'b0, 1'b1, 4'h4}); else pass++;
    queue_full_in = 1'b1;
    reset         = 1'b1;
    flush_in      = 1'b1;
    tick();
    reset         = 1'b0;
    flush_in      = 1'b0;
    queue_full_in = 1'b0;
    chk++; if ({stall_out, reserved_err_out, MajorOpcode_out, instr_count_out} !== {1'b1, 1'b0, 4'h0, 16'd0})
      $display("FAIL rst_emit got=%0h exp=%0h", {stall_out, reserved_err_out, MajorOpcode_out, instr_count_out}, {1'b1, 1'b0, 4'h0, 16'd0}); else pass++;
    chk++; if (Address_out !== 48'h0) $display("FAIL rst_emit_addr got=%0h exp=0", Address_out); else pass++;
  endtask

  task automatic test_wrap;
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    send(16'h1000);
    send(16'h0000);
    tick();
    chk++; if (instr_count_out !== 16'hFFFF) $display("FAIL wrap_ffff got=%0h exp=ffff", instr_count_out); else pass++;
    send(16'h1000);
    send(16'h0000);
    tick();
    chk++; if (instr_count_out !== 16'h0) $display("FAIL wrap_zero got=%0h exp=0", instr_count_out); else pass++;
  endtask

  initial begin
    reset           = 1'b1;
    parcel_in       = '0;
    parcel_valid_in = 1'b0;
    flush_in        = 1'b0;
    queue_full_in   = 1'b0;
    test_reset();
    test_plain();
    test_address();
    test_backpressure();
    test_flush();
    test_reserved_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/instruction_parcel_decoder.md
Name: instruction_parcel_decoder

Overview:
- Producer-side end of the instruction queue interface.
- Assembles 16-bit fetch parcels into one decoded instruction: a 32-bit base word plus an optional 48-bit address extension.
- Drives the queue's field inputs (MajorOpcode … OffsetSub) and its stall input. Honours queue backpressure.
- Sits between fetch and instruction_queue.

Parameters:
- PARCEL_W, 16, fetch parcel width; fixed, no other value supported.
- ADDR_W, 48, extension address width; must equal 3*PARCEL_W.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- parcel_in  in  16  fetch parcel
- parcel_valid_in  in  1  parcel_in holds a valid parcel
- parcel_ready_out  out  1  decoder accepts a parcel this cycle
- flush_in  in  1  discard any partial or held instruction
- queue_full_in  in  1  queue cannot accept an instruction this cycle
- MajorOpcode_out  out  4  base[31:28]
- Source1_out  out  5  base[27:23]
- Source2_out  out  5  base[22:18]
- OffsetScale_out  out  2  base[17:16]
- Destination_out  out  5  base[15:11]
- MinorOpcode_out  out  4  base[10:7]
- HasAddress_out  out  1  base[6]
- OffsetSub_out  out  1  base[5]
- Address_out  out  48  extension address; 0 when HasAddress_out=0
- stall_out  out  1  1 = no valid instruction presented; wires to the queue's stall_in
- reserved_err_out  out  1  base[4:0] nonzero for the presented instruction
- instr_count_out  out  16  instructions handed to the queue; wraps

Behaviour:
- Parcel transfer occurs when parcel_valid_in && parcel_ready_out.
- parcel_ready_out = 1 in states BASE_HI, BASE_LO, ADDR0, ADDR1, ADDR2; 0 in EMIT.
- FSM transitions:
  - BASE_HI: on transfer, capture base[31:16] -> BASE_LO.
  - BASE_LO: on transfer, capture base[15:0]. If bit 6 of this parcel = 1 -> ADDR0, else -> EMIT.
  - ADDR0 / ADDR1 / ADDR2: on transfer, capture Address[47:32], [31:16], [15:0] respectively. ADDR2 -> EMIT.
- EMIT:
  - All field outputs are registered and stay stable for the whole state; stall_out = 0.
  - If queue_full_in = 0: handoff occurs this cycle, instr_count_out increments next cycle, FSM -> BASE_HI, stall_out = 1 next cycle.
  - If queue_full_in = 1: hold indefinitely, with no change to any output.
- Latency: outputs become valid (stall_out = 0) the cycle after the final parcel transfers.
  - Minimum 3 cycles per instruction without an address, 6 cycles with one.
- While stall_out = 1, the field outputs hold their last values. The queue ignores them.
- Address_out is forced to 0 on entry to EMIT when HasAddress = 0.
- reserved_err_out is computed at the BASE_LO capture. It is informational only: the instruction is still emitted.
- flush_in (sync, takes effect next cycle):
  - FSM -> BASE_HI, stall_out = 1, partial parcels discarded.
  - A held EMIT instruction is dropped and not counted.
  - Flush overrides a parcel transfer in the same cycle: that parcel is consumed and discarded. This also applies when flush coincides with an EMIT handoff.
  - Field outputs keep their values.
- reset has priority over flush_in, including when asserted mid-instruction or mid-EMIT. Reset values:
  - FSM BASE_HI, stall_out = 1.
  - All field outputs, Address_out, reserved_err_out = 0.
  - instr_count_out = 0.
- instr_count_out wraps 16'hFFFF -> 0.

Decomposition:
- Shared package iq_pkg holds:
  - field bit-position constants (MAJOR_HI = 31 … OFFSUB_BIT = 5, RSVD field [4:0]);
  - ADDR_W = 48;
  - the FSM state enum (BASE_HI, BASE_LO, ADDR0, ADDR1, ADDR2, EMIT);
  - a packed decoded-instruction struct reused by instruction_queue.
- One sub-module, iq_field_extract: purely combinational slicing of the 32-bit base word into fields plus the reserved check. The FSM, address assembly and counter remain in the top.

Test Plan:
- Plain instruction: parcels 16'hFFFF, 16'hFF80 (bit 6 = 0), no backpressure.
  - stall_out = 0 one cycle after the 2nd transfer, with Major = F, Src1 = 1F, Src2 = 1F, OffsetScale = 3, Dest = 1F, Minor = F, HasAddress = 0, Address_out = 0.
  - instr_count_out = 1 afterwards.
- Address instruction: base 16'hFFFF, 16'hFFE0 (HasAddress = 1, OffsetSub = 1), then 16'h0000, 16'h0000, 16'h0062.
  - Address_out = 98 with HasAddress_out = 1, OffsetSub_out = 1, presented 6 cycles after the first parcel with continuous valid.
- Backpressure: queue_full_in = 1 for 5 cycles during EMIT.
  - Outputs stable and parcel_ready_out = 0 throughout; handoff on the first cycle queue_full_in = 0; count +1 exactly once.
- Flush: assert flush_in after ADDR0 has transferred.
  - stall_out stays 1, count unchanged, FSM in BASE_HI; next parcels decode as a fresh base word.
- Reserved and reset: base low parcel 16'h0003.
  - reserved_err_out = 1 and the instruction is still emitted.
  - Reset asserted during EMIT: next cycle stall_out = 1, all outputs 0, instr_count_out = 0.
- Wrap: preload the count via 65535 handoffs (or force) and issue one more instruction -> instr_count_out = 0.
